cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Multi-cycle control FSM for the 16-bit CPU; directly upstream of datapath.
//  Consumes the instruction register (instr) and PSR flags; drives every datapath enable/mux select.
//  One instruction per FETCH..last-state pass; PC updates only in an instruction's last state.
// PARAMETERS
//  SIZE      16   datapath word width (instr width)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears FSM to S_INIT
//  instr      in   16  IR contents: [15:12] op, [11:8] Rdest/cond, [7:4] opext/imm_hi, [3:0] Rsrc/imm_lo
//  flags1     in   2   PSR group1 {C,F}
//  flags2     in   3   PSR group2 {L,Z,N}
//  IRen       out  1   load IR from MemRead1
//  pcNexten   out  1   PC register load
//  MemW1en    out  1   bram port A write (tied 0; port A is fetch-only)
//  MemW2en    out  1   bram port B write (STOR)
//  RFen       out  1   register file write
//  PSRen      out  1   PSR update
//  PCm        out  2   0 PC+1, 1 RFread1 (Jcond/JAL), 2 aluOut (Bcond)
//  RWm        out  2   0 MemRead2, 1 PC+1 (JAL link), 2 MovMux, 3 luiImmd
//  A2m        out  2   0 RFread2, 1 zero-ext imm8, 2 sign-ext imm8
//  LUIm       out  1   ALU in1: 0 RFread1, 1 PC
//  Movm       out  1   0 A2MuxOut (MOV/MOVI), 1 aluOut
//  AluOp      out  4   ALU opcode from cpu_pkg
//  halted     out  1   FSM in S_HALT
// BEHAVIOUR
//  - Outputs are combinational from registered state + instr; all enables 0 in S_INIT and during reset.
//    Select defaults when unused: PCm=0, RWm=2, A2m=0, LUIm=0, Movm=1, AluOp=ALU_ADD.
//  - States: S_INIT -> S_FETCH -> S_DECODE -> {S_EXEC, S_LOAD_ADDR, S_STORE, S_BRANCH, S_JUMP, S_HALT}.
//  - S_INIT: one cycle after reset release, then S_FETCH.
//  - S_FETCH: bram port A addressed by PC; IRen=1 (1-cycle bram read latency lands in IR at edge).
//  - S_DECODE: no enables; classify instr[15:12] (and opext when op=0000/0100/1000).
//  - S_EXEC (R/I/shift/LUI/MOV): RFen=1, pcNexten=1, PCm=0; PSRen=1 only for ADD/ADDC/SUB/SUBC/CMP and
//    immediate forms; CMP/CMPI: RFen=0. A2m=1 for logical imm, 2 for arithmetic imm; LUI: RWm=3.
//  - S_LOAD_ADDR: MemAddr2=RFread2 presented -> S_LOAD_WB: RWm=0, RFen=1, pcNexten=1.  LOAD = 4 cycles.
//  - S_STORE: MemW2en=1, pcNexten=1 -> S_FETCH. 3 cycles.
//  - S_BRANCH (op 1100): cond=instr[11:8] evaluated on current flags; taken: LUIm=1, A2m=2, AluOp=ADD,
//    PCm=2 (target = PC + sext(disp8)); not taken: PCm=0. pcNexten=1 either way.
//  - S_JUMP (op 0100, opext 1100 Jcond / 1000 JAL): Jcond taken PCm=1 else 0; JAL: RWm=1, RFen=1, PCm=1.
//  - Condition 1110 always true, 1111 never true; table per cpu_pkg.
//  - Undefined opcode/opext -> S_HALT; stays until reset; all enables 0, halted=1.
//  - Flags sampled in S_BRANCH/S_JUMP reflect PSR after the previous instruction's last edge.
//  - Reset asserted mid-instruction: abort immediately, no partial write completes after assertion.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: extra input port step (1 bit); FSM waits in S_FETCH with IRen=0
//    until step=1 sampled; one instruction executes per step pulse (level held = free-run).
//  Undefined: no step port; S_FETCH always proceeds next cycle.
// STRUCTURE
//  cpu_pkg: state enum, opcode/opext localparams, AluOp codes, cond codes, mux select constants.
//  Sub-module cond_eval (cond[3:0], flags1, flags2 -> taken), combinational, shared with Scond later.
// TESTING
//  1. Reset held 3 cycles, release -> all enables 0, S_INIT one cycle, IRen=1 next cycle.
//  2. instr=16'h0512 (ADD R5,R2): S_EXEC asserts RFen=1, PSRen=1, AluOp=ALU_ADD, A2m=0, pcNexten=1, 3 cycles.
//  3. instr=16'h4304 LOAD -> MemW2en=0, RWm=0, RFen=1 only in S_LOAD_WB, total 4 cycles.
//  4. instr=16'hC0FE (BEQ -2): Z=1 -> PCm=2, A2m=2, LUIm=1; Z=0 -> PCm=0.
//  5. instr=16'h4E8A JAL -> RFen=1, RWm=1, PCm=1; instr=16'hF000 undefined op -> halted=1 until reset.
//  6. Reset asserted in S_STORE -> MemW2en drops same cycle, FSM in S_INIT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: FSM states, opcode/opext maps,
// ALU codes, branch condition codes, datapath mux selects and the instruction decoder.
package cpu_pkg;

    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC      = 4'd3;
    localparam logic [3:0] S_LOAD_ADDR = 4'd4;
    localparam logic [3:0] S_LOAD_WB   = 4'd5;
    localparam logic [3:0] S_STORE     = 4'd6;
    localparam logic [3:0] S_BRANCH    = 4'd7;
    localparam logic [3:0] S_JUMP      = 4'd8;
    localparam logic [3:0] S_HALT      = 4'd9;

    // Primary opcodes, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1110;

    // Register-register extensions (op 0000), instr[7:4]
    localparam logic [3:0] X_ADD  = 4'b0001;
    localparam logic [3:0] X_ADDC = 4'b0010;
    localparam logic [3:0] X_SUB  = 4'b0011;
    localparam logic [3:0] X_SUBC = 4'b0100;
    localparam logic [3:0] X_CMP  = 4'b0101;
    localparam logic [3:0] X_AND  = 4'b0110;
    localparam logic [3:0] X_OR   = 4'b0111;
    localparam logic [3:0] X_XOR  = 4'b1000;
    localparam logic [3:0] X_MOV  = 4'b1001;

    // Shift extensions (op 1000)
    localparam logic [3:0] SX_LSHI  = 4'b0000;
    localparam logic [3:0] SX_ASHUI = 4'b0010;
    localparam logic [3:0] SX_LSH   = 4'b0100;
    localparam logic [3:0] SX_ASHU  = 4'b0110;

    // Memory / jump extensions (op 0100)
    localparam logic [3:0] MX_LOAD  = 4'b0000;
    localparam logic [3:0] MX_STOR  = 4'b0100;
    localparam logic [3:0] MX_JAL   = 4'b1000;
    localparam logic [3:0] MX_JCOND = 4'b1100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDC = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBC = 4'd3;
    localparam logic [3:0] ALU_CMP  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_LSH  = 4'd8;
    localparam logic [3:0] ALU_ASHU = 4'd9;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_CS = 4'b0010;
    localparam logic [3:0] C_CC = 4'b0011;
    localparam logic [3:0] C_HI = 4'b0100;
    localparam logic [3:0] C_LS = 4'b0101;
    localparam logic [3:0] C_GT = 4'b0110;
    localparam logic [3:0] C_LE = 4'b0111;
    localparam logic [3:0] C_FS = 4'b1000;
    localparam logic [3:0] C_FC = 4'b1001;
    localparam logic [3:0] C_LO = 4'b1010;
    localparam logic [3:0] C_HS = 4'b1011;
    localparam logic [3:0] C_LT = 4'b1100;
    localparam logic [3:0] C_GE = 4'b1101;
    localparam logic [3:0] C_UC = 4'b1110;
    localparam logic [3:0] C_NV = 4'b1111;

    localparam logic [1:0] PCM_INC   = 2'd0;
    localparam logic [1:0] PCM_RF    = 2'd1;
    localparam logic [1:0] PCM_ALU   = 2'd2;
    localparam logic [1:0] RWM_MEM   = 2'd0;
    localparam logic [1:0] RWM_LINK  = 2'd1;
    localparam logic [1:0] RWM_MOV   = 2'd2;
    localparam logic [1:0] RWM_LUI   = 2'd3;
    localparam logic [1:0] A2M_RF    = 2'd0;
    localparam logic [1:0] A2M_ZEXT  = 2'd1;
    localparam logic [1:0] A2M_SEXT  = 2'd2;
    localparam logic       LUIM_RF   = 1'b0;
    localparam logic       LUIM_PC   = 1'b1;
    localparam logic       MOVM_A2   = 1'b0;
    localparam logic       MOVM_ALU  = 1'b1;

    typedef struct packed {
        logic       valid;
        logic       rf_wr;
        logic       psr_wr;
        logic       lui;
        logic [1:0] a2m;
        logic       mov_sel;
        logic [3:0] alu_op;
    } exec_ctrl_t;

    // Controls for single-state ALU/move instructions; valid=0 marks an undefined encoding.
    function automatic exec_ctrl_t exec_decode(input logic [3:0] op, input logic [3:0] opext);
        exec_ctrl_t c;
        c.valid   = 1'b1;
        c.rf_wr   = 1'b1;
        c.psr_wr  = 1'b0;
        c.lui     = 1'b0;
        c.a2m     = A2M_RF;
        c.mov_sel = MOVM_ALU;
        c.alu_op  = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (opext)
                    X_ADD:  begin c.alu_op = ALU_ADD;  c.psr_wr = 1'b1; end
                    X_ADDC: begin c.alu_op = ALU_ADDC; c.psr_wr = 1'b1; end
                    X_SUB:  begin c.alu_op = ALU_SUB;  c.psr_wr = 1'b1; end
                    X_SUBC: begin c.alu_op = ALU_SUBC; c.psr_wr = 1'b1; end
                    X_CMP:  begin c.alu_op = ALU_CMP;  c.psr_wr = 1'b1; c.rf_wr = 1'b0; end
                    X_AND:  c.alu_op = ALU_AND;
                    X_OR:   c.alu_op = ALU_OR;
                    X_XOR:  c.alu_op = ALU_XOR;
                    X_MOV:  c.mov_sel = MOVM_A2;
                    default: c.valid = 1'b0;
                endcase
            end
            OP_ANDI:  begin c.alu_op = ALU_AND;  c.a2m = A2M_ZEXT; end
            OP_ORI:   begin c.alu_op = ALU_OR;   c.a2m = A2M_ZEXT; end
            OP_XORI:  begin c.alu_op = ALU_XOR;  c.a2m = A2M_ZEXT; end
            OP_ADDI:  begin c.alu_op = ALU_ADD;  c.a2m = A2M_SEXT; c.psr_wr = 1'b1; end
            OP_ADDCI: begin c.alu_op = ALU_ADDC; c.a2m = A2M_SEXT; c.psr_wr = 1'b1; end
            OP_SUBI:  begin c.alu_op = ALU_SUB;  c.a2m = A2M_SEXT; c.psr_wr = 1'b1; end
            OP_SUBCI: begin c.alu_op = ALU_SUBC; c.a2m = A2M_SEXT; c.psr_wr = 1'b1; end
            OP_CMPI:  begin c.alu_op = ALU_CMP;  c.a2m = A2M_SEXT; c.psr_wr = 1'b1; c.rf_wr = 1'b0; end
            OP_MOVI:  begin c.a2m = A2M_ZEXT; c.mov_sel = MOVM_A2; end
            OP_LUI:   c.lui = 1'b1;
            OP_SHIFT: begin
                // Shift amounts are signed (negative = right), hence sign extension.
                case (opext)
                    SX_LSHI:  begin c.alu_op = ALU_LSH;  c.a2m = A2M_SEXT; end
                    SX_ASHUI: begin c.alu_op = ALU_ASHU; c.a2m = A2M_SEXT; end
                    SX_LSH:   c.alu_op = ALU_LSH;
                    SX_ASHU:  c.alu_op = ALU_ASHU;
                    default:  c.valid = 1'b0;
                endcase
            end
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] decode_next(input logic [3:0] op, input logic [3:0] opext);
        logic [3:0] nxt;
        case (op)
            OP_MEMJ: begin
                case (opext)
                    MX_LOAD:  nxt = S_LOAD_ADDR;
                    MX_STOR:  nxt = S_STORE;
                    MX_JAL:   nxt = S_JUMP;
                    MX_JCOND: nxt = S_JUMP;
                    default:  nxt = S_HALT;
                endcase
            end
            OP_BCOND: nxt = S_BRANCH;
            default: begin
                if (exec_decode(op, opext).valid) begin
                    nxt = S_EXEC;
                end else begin
                    nxt = S_HALT;
                end
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and PSR flags to taken.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [1:0] flags1,
    input  logic [2:0] flags2,
    output logic       taken
);

    logic c_flag, f_flag, l_flag, z_flag, n_flag;

    assign c_flag = flags1[1];
    assign f_flag = flags1[0];
    assign l_flag = flags2[2];
    assign z_flag = flags2[1];
    assign n_flag = flags2[0];

    // Condition table lookup
    always_comb begin
        taken = 1'b0;
        case (cond)
            C_EQ:    taken = z_flag;
            C_NE:    taken = ~z_flag;
            C_CS:    taken = c_flag;
            C_CC:    taken = ~c_flag;
            C_HI:    taken = l_flag;
            C_LS:    taken = ~l_flag;
            C_GT:    taken = n_flag;
            C_LE:    taken = ~n_flag;
            C_FS:    taken = f_flag;
            C_FC:    taken = ~f_flag;
            C_LO:    taken = ~l_flag & ~z_flag;
            C_HS:    taken = l_flag | z_flag;
            C_LT:    taken = ~n_flag & ~z_flag;
            C_GE:    taken = n_flag | z_flag;
            C_UC:    taken = 1'b1;
            C_NV:    taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 16-bit CPU; outputs decode from the state register and instr.
// Optional CTRL_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [SIZE-1:0] instr,
    input  logic [1:0]      flags1,
    input  logic [2:0]      flags2,
    output logic            IRen,
    output logic            pcNexten,
    output logic            MemW1en,
    output logic            MemW2en,
    output logic            RFen,
    output logic            PSRen,
    output logic [1:0]      PCm,
    output logic [1:0]      RWm,
    output logic [1:0]      A2m,
    output logic            LUIm,
    output logic            Movm,
    output logic [3:0]      AluOp,
    output logic            halted
);

    logic [3:0] state_r;
    logic [3:0] state_next_s;
    logic [3:0] op_s;
    logic [3:0] opext_s;
    logic       taken_s;
    logic       fetch_go_s;
    exec_ctrl_t exec_s;
    logic       unused_lo_s;

    assign op_s        = instr[15:12];
    assign opext_s     = instr[7:4];
    assign exec_s      = exec_decode(op_s, opext_s);
    assign unused_lo_s = ^instr[3:0];

`ifdef CTRL_SINGLE_STEP_EN
    assign fetch_go_s = step;
`else
    assign fetch_go_s = 1'b1;
`endif

    cond_eval u_cond_eval (
        .cond   (instr[11:8]),
        .flags1 (flags1),
        .flags2 (flags2),
        .taken  (taken_s)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = S_INIT;
        case (state_r)
            S_INIT:      state_next_s = S_FETCH;
            S_FETCH: begin
                if (fetch_go_s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE:    state_next_s = decode_next(op_s, opext_s);
            S_EXEC:      state_next_s = S_FETCH;
            S_LOAD_ADDR: state_next_s = S_LOAD_WB;
            S_LOAD_WB:   state_next_s = S_FETCH;
            S_STORE:     state_next_s = S_FETCH;
            S_BRANCH:    state_next_s = S_FETCH;
            S_JUMP:      state_next_s = S_FETCH;
            S_HALT:      state_next_s = S_HALT;
            default:     state_next_s = S_INIT;
        endcase
    end

    // Datapath control decode
    always_comb begin
        IRen     = 1'b0;
        pcNexten = 1'b0;
        MemW1en  = 1'b0;
        MemW2en  = 1'b0;
        RFen     = 1'b0;
        PSRen    = 1'b0;
        PCm      = PCM_INC;
        RWm      = RWM_MOV;
        A2m      = A2M_RF;
        LUIm     = LUIM_RF;
        Movm     = MOVM_ALU;
        AluOp    = ALU_ADD;
        halted   = 1'b0;
        case (state_r)
            S_FETCH: IRen = fetch_go_s;
            S_EXEC: begin
                pcNexten = 1'b1;
                RFen     = exec_s.valid & exec_s.rf_wr;
                PSRen    = exec_s.valid & exec_s.psr_wr;
                A2m      = exec_s.a2m;
                Movm     = exec_s.mov_sel;
                AluOp    = exec_s.alu_op;
                if (exec_s.lui) begin
                    RWm = RWM_LUI;
                end else begin
                    RWm = RWM_MOV;
                end
            end
            S_LOAD_WB: begin
                RWm      = RWM_MEM;
                RFen     = 1'b1;
                pcNexten = 1'b1;
            end
            S_STORE: begin
                MemW2en  = 1'b1;
                pcNexten = 1'b1;
            end
            S_BRANCH: begin
                pcNexten = 1'b1;
                // Taken target is PC + sext(disp8) computed by the ALU
                if (taken_s) begin
                    LUIm  = LUIM_PC;
                    A2m   = A2M_SEXT;
                    AluOp = ALU_ADD;
                    PCm   = PCM_ALU;
                end else begin
                    PCm = PCM_INC;
                end
            end
            S_JUMP: begin
                pcNexten = 1'b1;
                if (opext_s == MX_JAL) begin
                    RWm  = RWM_LINK;
                    RFen = 1'b1;
                    PCm  = PCM_RF;
                end else if (taken_s) begin
                    PCm = PCM_RF;
                end else begin
                    PCm = PCM_INC;
                end
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller (default build; step tied high if enabled).
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [1:0]  flags1;
    logic [2:0]  flags2;
    logic        IRen, pcNexten, MemW1en, MemW2en, RFen, PSRen, LUIm, Movm, halted;
    logic [1:0]  PCm, RWm, A2m;
    logic [3:0]  AluOp;

    int n_cmp;
    int n_err;

    wire [7:0] en   = {2'b00, IRen, pcNexten, MemW1en, MemW2en, RFen, PSRen};
    wire [7:0] sel  = {PCm, RWm, A2m, LUIm, Movm};
    wire [7:0] misc = {3'b000, halted, AluOp};

    cpu_controller #(.SIZE(16)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef CTRL_SINGLE_STEP_EN
        .step     (1'b1),
`endif
        .instr    (instr),
        .flags1   (flags1),
        .flags2   (flags2),
        .IRen     (IRen),
        .pcNexten (pcNexten),
        .MemW1en  (MemW1en),
        .MemW2en  (MemW2en),
        .RFen     (RFen),
        .PSRen    (PSRen),
        .PCm      (PCm),
        .RWm      (RWm),
        .A2m      (A2m),
        .LUIm     (LUIm),
        .Movm     (Movm),
        .AluOp    (AluOp),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // en order: IRen pcNexten MemW1en MemW2en RFen PSRen
    // sel order: PCm RWm A2m LUIm Movm ; misc: halted AluOp
    initial begin
        n_cmp  = 0;
        n_err  = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        instr  = 16'h0512;
        flags1 = 2'b00;
        flags2 = 3'b000;

        repeat (3) cyc();
        chk("reset_en", en, 8'b00_000000);
        chk("reset_halt", misc, 8'h00);
        reset = 1'b0;
        #1;
        chk("init_en", en, 8'b00_000000);

        // ADD R5,R2
        cyc(); chk("add_fetch", en, 8'b00_100000);
        cyc(); chk("add_decode", en, 8'b00_000000);
        cyc(); chk("add_exec_en", en, 8'b00_010011);
        chk("add_exec_sel", sel, 8'b00_10_00_0_1);
        chk("add_exec_alu", misc, 8'h00);

        // LOAD
        cyc(); chk("load_fetch", en, 8'b00_100000);
        instr = 16'h4304;
        cyc(); chk("load_decode", en, 8'b00_000000);
        cyc(); chk("load_addr_en", en, 8'b00_000000);
        cyc(); chk("load_wb_en", en, 8'b00_010010);
        chk("load_wb_sel", sel, 8'b00_00_00_0_1);

        // CMP R3,R2: flags only
        cyc(); chk("cmp_fetch", en, 8'b00_100000);
        instr = 16'h0352;
        cyc(); cyc();
        chk("cmp_exec_en", en, 8'b00_010001);
        chk("cmp_exec_alu", misc, 8'h04);

        // ANDI: zero-extended immediate, no PSR update
        cyc(); instr = 16'h13FF;
        cyc(); cyc();
        chk("andi_exec_en", en, 8'b00_010010);
        chk("andi_exec_sel", sel, 8'b00_10_01_0_1);
        chk("andi_exec_alu", misc, 8'h05);

        // BEQ -2, taken then not taken
        cyc(); instr = 16'hC0FE; flags2 = 3'b010;
        cyc(); cyc();
        chk("beq_t_en", en, 8'b00_010000);
        chk("beq_t_sel", sel, 8'b10_10_10_1_1);
        chk("beq_t_alu", misc, 8'h00);
        cyc(); flags2 = 3'b000;
        cyc(); cyc();
        chk("beq_nt_en", en, 8'b00_010000);
        chk("beq_nt_sel", sel, 8'b00_10_00_0_1);

        // JAL, then Jcond always / never
        cyc(); instr = 16'h4E8A;
        cyc(); cyc();
        chk("jal_en", en, 8'b00_010010);
        chk("jal_sel", sel, 8'b01_01_00_0_1);
        cyc(); instr = 16'h4EC3;
        cyc(); cyc();
        chk("juc_sel", sel, 8'b01_10_00_0_1);
        cyc(); instr = 16'h4FC3;
        cyc(); cyc();
        chk("jnv_en", en, 8'b00_010000);
        chk("jnv_sel", sel, 8'b00_10_00_0_1);

        // STOR, reset asserted mid-state
        cyc(); instr = 16'h4244;
        cyc(); cyc();
        chk("stor_en", en, 8'b00_010100);
        reset = 1'b1;
        #1;
        chk("stor_abort_en", en, 8'b00_000000);
        chk("stor_abort_halt", misc, 8'h00);
        cyc();
        chk("stor_reset_hold", en, 8'b00_000000);
        reset = 1'b0;
        cyc(); chk("post_reset_fetch", en, 8'b00_100000);

        // Undefined opcode halts until reset
        instr = 16'hF000;
        cyc(); cyc();
        chk("halt_en", en, 8'b00_000000);
        chk("halt_flag", misc, 8'h10);
        repeat (3) cyc();
        chk("halt_sticky", misc, 8'h10);
        chk("halt_sticky_en", en, 8'b00_000000);
        reset = 1'b1;
        #1;
        chk("halt_reset", misc, 8'h00);
        cyc();
        reset = 1'b0;
        cyc(); chk("halt_refetch", en, 8'b00_100000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
